punc_mem_responder: RTL and testbench

//  Memory-side responder for PUnC control-unit load/store and instruction-fetch requests.

---
 rtl/punc_mem_responder.sv | 154 +++++++++++++++
 tb/tb_punc_mem_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/punc_mem_responder.sv
// Word-addressed memory responder for PUnC load/store/fetch traffic.
// One request in flight; fixed latency from accept to response; preload port for boot fill.
module punc_mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [15:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    input  logic                  ld_en,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  busy
);
    // Handshakes: a transfer happens on any posedge where valid and ready are both high.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [15:0]           addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  commit;
    logic                  acc_we;
    logic [15:0]           acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    assign req_ready  = !rst && (state_q == S_IDLE) && !ld_en;
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign busy       = (state_q != S_IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        commit    = 1'b0;
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        mem_we    = 1'b0;
        mem_waddr = ld_addr;
        mem_wdata = ld_data;

        case (state_q)
            S_IDLE: begin
                if (ld_en) begin
                    mem_we = 1'b1;
                end else if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_INIT;
                    // Single-cycle latency commits on the accept edge straight from the request bus.
                    if (LATENCY == 1) begin
                        commit    = 1'b1;
                        acc_we    = req_we;
                        acc_addr  = req_addr;
                        acc_wdata = req_wdata;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    commit = 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            state_d = S_RESP;
            if (acc_addr[15:ADDR_WIDTH] != '0) begin
                rdata_d = '0;
                err_d   = 1'b1;
            end else if (acc_we) begin
                mem_we    = 1'b1;
                mem_waddr = acc_addr[ADDR_WIDTH-1:0];
                mem_wdata = acc_wdata;
                rdata_d   = '0;
                err_d     = 1'b0;
            end else begin
                rdata_d = mem[acc_addr[ADDR_WIDTH-1:0]];
                err_d   = 1'b0;
            end
        end

        // Reset drops any uncommitted store and any preload on the same edge.
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_punc_mem_responder.sv
// Bench for punc_mem_responder: directed requests against a transaction-level model,
// a per-cycle compare process, and literal checks; a second LATENCY=1 instance covers single-cycle timing.
module tb_punc_mem_responder;
    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        req_valid, req_we, resp_ready, ld_en;
    logic [15:0] req_addr, req_wdata, ld_data;
    logic [7:0]  ld_addr;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [15:0] resp_rdata;

    logic        b_req_valid, b_req_we, b_resp_ready, b_ld_en;
    logic [15:0] b_req_addr, b_req_wdata, b_ld_data;
    logic [7:0]  b_ld_addr;
    logic        b_req_ready, b_resp_valid, b_resp_err, b_busy;
    logic [15:0] b_resp_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    punc_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .busy(busy)
    );

    punc_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .resp_valid(b_resp_valid),
        .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data), .busy(b_busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one request in flight, response appears LAT edges after accept.
    logic [15:0] m_mem [256];
    bit          m_busy  = 0;
    bit          m_resp  = 0;
    bit          m_err   = 0;
    logic [15:0] m_rdata = '0;
    bit          m_we;
    logic [15:0] m_addr, m_wdata;
    int          m_edges_left;

    task automatic m_commit();
        m_resp = 1;
        if (m_addr > 16'h00ff) begin
            m_err   = 1;
            m_rdata = '0;
        end else if (m_we) begin
            m_mem[m_addr[7:0]] = m_wdata;
            m_rdata = '0;
            m_err   = 0;
        end else begin
            m_rdata = m_mem[m_addr[7:0]];
            m_err   = 0;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_resp = 0; m_err = 0; m_rdata = '0;
        end else if (m_resp) begin
            if (resp_ready) begin
                m_resp = 0; m_busy = 0; m_err = 0;
            end
        end else if (m_busy) begin
            m_edges_left--;
            if (m_edges_left == 0) m_commit();
        end else if (ld_en) begin
            m_mem[ld_addr] = ld_data;
        end else if (req_valid) begin
            m_busy = 1; m_we = req_we; m_addr = req_addr; m_wdata = req_wdata;
            m_edges_left = LAT - 1;
            if (m_edges_left == 0) m_commit();
        end
    end

    // scoreboard compare, every cycle once reset has been applied
    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", {31'd0, req_ready}, {31'd0, !m_busy && !ld_en && !rst});
            check("resp_valid", {31'd0, resp_valid}, {31'd0, m_resp});
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("resp_err", {31'd0, resp_err}, {31'd0, m_err});
            if (m_resp) check("resp_rdata", {16'd0, resp_rdata}, {16'd0, m_rdata});
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        ld_en = 1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 0;
    endtask

    task automatic do_req(input logic we, input logic [15:0] a, input logic [15:0] wd,
                          output logic [15:0] rd, output logic er, output int lat);
        int n;
        req_we = we; req_addr = a; req_wdata = wd; req_valid = 1;
        #1;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("accept_timeout", n, 0);
        tick();
        req_valid = 0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            tick();
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
    endtask

    logic [15:0] rd;
    logic        er;
    int          lat;
    logic [15:0] tbl_addr [4];
    logic [15:0] tbl_data [4];

    initial begin
        rst = 1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
        resp_ready = 1; ld_en = 0; ld_addr = '0; ld_data = '0;
        b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0;
        b_resp_ready = 1; b_ld_en = 0; b_ld_addr = '0; b_ld_data = '0;
        tick();
        chk_en = 1;
        tick();
        check("rst_req_ready", {31'd0, req_ready}, 0);
        check("rst_resp_valid", {31'd0, resp_valid}, 0);
        check("rst_rdata", {16'd0, resp_rdata}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        rst = 0;
        tick();

        // preload then load
        preload(8'h10, 16'h1234);
        do_req(0, 16'h0010, 16'h0, rd, er, lat);
        check("t1_latency", lat, 2);
        check("t1_rdata", {16'd0, rd}, 32'h1234);
        check("t1_err", {31'd0, er}, 0);
        tick();
        check("t1_busy_fall", {31'd0, busy}, 0);

        // store then read-after-write
        do_req(1, 16'h0020, 16'hBEEF, rd, er, lat);
        check("t2_store_rdata", {16'd0, rd}, 0);
        check("t2_store_err", {31'd0, er}, 0);
        tick();
        do_req(0, 16'h0020, 16'h0, rd, er, lat);
        check("t2_load_rdata", {16'd0, rd}, 32'hBEEF);
        tick();

        // out-of-range load and store
        preload(8'h00, 16'h5A5A);
        do_req(0, 16'h0300, 16'h0, rd, er, lat);
        check("t3_oor_err", {31'd0, er}, 1);
        check("t3_oor_rdata", {16'd0, rd}, 0);
        tick();
        do_req(1, 16'h0300, 16'h1111, rd, er, lat);
        check("t3_oor_store_err", {31'd0, er}, 1);
        tick();
        do_req(0, 16'h0000, 16'h0, rd, er, lat);
        check("t3_mem0_kept", {16'd0, rd}, 32'h5A5A);
        tick();

        // backpressure for five cycles, new request offered during the handshake
        preload(8'h33, 16'hC0DE);
        resp_ready = 0;
        do_req(0, 16'h0033, 16'h0, rd, er, lat);
        req_valid = 1; req_we = 1; req_addr = 16'h0033; req_wdata = 16'hDEAD;
        for (int i = 0; i < 5; i++) begin
            check("t4_valid_held", {31'd0, resp_valid}, 1);
            check("t4_rdata_held", {16'd0, resp_rdata}, 32'hC0DE);
            check("t4_ready_low", {31'd0, req_ready}, 0);
            tick();
        end
        resp_ready = 1;
        tick();
        req_valid = 0;
        #1;
        check("t4_idle_busy", {31'd0, busy}, 0);
        check("t4_idle_valid", {31'd0, resp_valid}, 0);
        do_req(0, 16'h0033, 16'h0, rd, er, lat);
        check("t4_no_stray_store", {16'd0, rd}, 32'hC0DE);
        tick();

        // reset during WAIT of a store drops it
        preload(8'h05, 16'h0007);
        req_valid = 1; req_we = 1; req_addr = 16'h0005; req_wdata = 16'hAAAA;
        tick();
        req_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        check("t5_valid_after_rst", {31'd0, resp_valid}, 0);
        check("t5_busy_after_rst", {31'd0, busy}, 0);
        do_req(0, 16'h0005, 16'h0, rd, er, lat);
        check("t5_store_dropped", {16'd0, rd}, 32'h0007);
        tick();

        // preload wins over a simultaneous request
        ld_en = 1; ld_addr = 8'h40; ld_data = 16'h4242;
        req_valid = 1; req_we = 0; req_addr = 16'h0040;
        #1;
        check("t6_ready_low_ld", {31'd0, req_ready}, 0);
        tick();
        ld_en = 0;
        do_req(0, 16'h0040, 16'h0, rd, er, lat);
        check("t6_rdata", {16'd0, rd}, 32'h4242);
        tick();

        // a few store/load pairs
        tbl_addr = '{16'h0001, 16'h00ff, 16'h0080, 16'h007f};
        tbl_data = '{16'h0f0f, 16'hffff, 16'h8001, 16'h3c3c};
        for (int i = 0; i < 4; i++) begin
            do_req(1, tbl_addr[i], tbl_data[i], rd, er, lat);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            do_req(0, tbl_addr[i], 16'h0, rd, er, lat);
            check("tbl_rdata", {16'd0, rd}, {16'd0, tbl_data[i]});
            tick();
        end

        // LATENCY=1 instance
        b_ld_en = 1; b_ld_addr = 8'h40; b_ld_data = 16'h9876;
        b_req_valid = 1; b_req_we = 0; b_req_addr = 16'h0040;
        #1;
        check("l1_ready_low_ld", {31'd0, b_req_ready}, 0);
        tick();
        b_ld_en = 0;
        #1;
        check("l1_ready_high", {31'd0, b_req_ready}, 1);
        tick();
        b_req_valid = 0;
        check("l1_valid_t1", {31'd0, b_resp_valid}, 1);
        check("l1_rdata", {16'd0, b_resp_rdata}, 32'h9876);
        check("l1_err", {31'd0, b_resp_err}, 0);
        tick();
        check("l1_busy_fall", {31'd0, b_busy}, 0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
